// File: rtl/ll_req_arbiter_pkg.sv
// Shared definitions for the linked-list request arbiter: op classes,
// sequencer states and the address-width helper.
package ll_pkg;

  localparam logic [1:0] OP_READ     = 2'd0;
  localparam logic [1:0] OP_INSERT   = 2'd1;
  localparam logic [1:0] OP_DEL_VAL  = 2'd2;
  localparam logic [1:0] OP_DEL_ADDR = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  // Node addresses run 0..MAX_NODE, so one extra code point is needed.
  function automatic int ll_addr_w(input int max_node);
    return $clog2(max_node + 1);
  endfunction

  // Inserts can only fail on a full list; every other class needs a node.
  function automatic logic pre_reject(input logic [1:0] op_class,
                                      input logic       full,
                                      input logic       empty);
    return (op_class == OP_INSERT) ? full : empty;
  endfunction

endpackage

// File: rtl/ll_req_arbiter_rr.sv
// Combinational round-robin grant: searches upward from ptr_i+1 with wrap
// and returns a one-hot grant plus its index.
module rr_arbiter_comb #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               any_o
);

  logic [IDX_W-1:0] idx;

  // NOTE: every output gets a default before the search so no path through
  // the loop leaves a variable unassigned and infers a latch.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    idx       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
      if (!any_o && req_i[idx]) begin
        any_o      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
      end
    end
  end

endmodule

// File: rtl/ll_req_arbiter.sv
// Round-robin sequencer sharing one linked-list instance between NUM_REQ
// requesters, with local rejection of doomed ops and a hang watchdog.
module ll_req_arbiter
  import ll_pkg::*;
#(
  parameter  int NUM_REQ     = 4,
  parameter  int DATA_WIDTH  = 8,
  parameter  int MAX_NODE    = 8,
  parameter  int TIMEOUT_CYC = 4 * MAX_NODE + 8,
  localparam int ADDR_WIDTH  = ll_addr_w(MAX_NODE)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*3-1:0]             req_op,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  output logic [ADDR_WIDTH-1:0]            rsp_next_addr,
  output logic                             rsp_fault,
  output logic                             err_timeout,
  output logic [2:0]                       ll_op,
  output logic                             ll_op_start,
  output logic [DATA_WIDTH-1:0]            ll_data_in,
  output logic [ADDR_WIDTH-1:0]            ll_addr_in,
  input  logic                             ll_op_done,
  input  logic [DATA_WIDTH-1:0]            ll_data_out,
  input  logic [ADDR_WIDTH-1:0]            ll_next_node_addr,
  input  logic                             ll_fault,
  input  logic                             ll_full,
  input  logic                             ll_empty
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  state_e                  state_q;
  logic [IDX_W-1:0]        rr_ptr_q;
  logic [NUM_REQ-1:0]      srv_q;
  logic [WD_W-1:0]         wd_q;
  logic [2:0]              ll_op_q;
  logic                    ll_op_start_q;
  logic [DATA_WIDTH-1:0]   ll_data_q;
  logic [ADDR_WIDTH-1:0]   ll_addr_q;
  logic [NUM_REQ-1:0]      rsp_valid_q;
  logic [DATA_WIDTH-1:0]   rsp_data_q;
  logic [ADDR_WIDTH-1:0]   rsp_next_q;
  logic                    rsp_fault_q;
  logic                    err_timeout_q;

  logic [NUM_REQ-1:0]      gnt;
  logic [IDX_W-1:0]        gnt_idx;
  logic                    gnt_any;
  logic [2:0]              sel_op_d;
  logic [DATA_WIDTH-1:0]   sel_data_d;
  logic [ADDR_WIDTH-1:0]   sel_addr_d;
  logic                    rej_d;
  logic                    srv_is_read;

  rr_arbiter_comb #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req_i     (req_valid),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .any_o     (gnt_any)
  );

  always_comb begin
    sel_op_d   = '0;
    sel_data_d = '0;
    sel_addr_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_op_d   = req_op[i*3 +: 3];
        sel_data_d = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_addr_d = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  assign rej_d       = pre_reject(sel_op_d[1:0], ll_full, ll_empty);
  assign srv_is_read = (ll_op_q[1:0] == OP_READ);

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      rr_ptr_q      <= IDX_W'(NUM_REQ - 1);
      srv_q         <= '0;
      wd_q          <= '0;
      ll_op_q       <= '0;
      ll_op_start_q <= 1'b0;
      ll_data_q     <= '0;
      ll_addr_q     <= '0;
      rsp_valid_q   <= '0;
      rsp_data_q    <= '0;
      rsp_next_q    <= '0;
      rsp_fault_q   <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      case (state_q)
        IDLE: begin
          if (gnt_any) begin
            rr_ptr_q  <= gnt_idx;
            srv_q     <= gnt;
            ll_op_q   <= sel_op_d;
            ll_data_q <= sel_data_d;
            ll_addr_q <= sel_addr_d;
            if (rej_d) begin
              state_q     <= RESP;
              rsp_valid_q <= gnt;
              rsp_fault_q <= 1'b1;
              rsp_data_q  <= '0;
              rsp_next_q  <= '0;
            end else begin
              state_q       <= ISSUE;
              ll_op_start_q <= 1'b1;
              wd_q          <= '0;
            end
          end
        end

        ISSUE: begin
          if (ll_op_done) begin
            state_q       <= RESP;
            ll_op_start_q <= 1'b0;
            rsp_valid_q   <= srv_q;
            rsp_fault_q   <= ll_fault;
            if (srv_is_read && !ll_fault) begin
              rsp_data_q <= ll_data_out;
              rsp_next_q <= ll_next_node_addr;
            end else begin
              rsp_data_q <= '0;
              rsp_next_q <= '0;
            end
          end else if (wd_q == WD_LAST) begin
            // The list never answered: abandon the op and fail it upstream.
            state_q       <= RESP;
            ll_op_start_q <= 1'b0;
            rsp_valid_q   <= srv_q;
            rsp_fault_q   <= 1'b1;
            rsp_data_q    <= '0;
            rsp_next_q    <= '0;
            err_timeout_q <= 1'b1;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end

        RESP: begin
          state_q     <= IDLE;
          rsp_fault_q <= 1'b0;
          rsp_data_q  <= '0;
          rsp_next_q  <= '0;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  // Acceptance is only offered from IDLE and never while reset is held.
  assign req_ready     = (state_q == IDLE && rst) ? gnt : '0;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_next_addr = rsp_next_q;
  assign rsp_fault     = rsp_fault_q;
  assign err_timeout   = err_timeout_q;
  assign ll_op         = ll_op_q;
  assign ll_op_start   = ll_op_start_q;
  assign ll_data_in    = ll_data_q;
  assign ll_addr_in    = ll_addr_q;

endmodule

// File: tb/tb_ll_req_arbiter.sv
// Bench for ll_req_arbiter: behavioural list model, response scoreboard,
// table-driven single ops plus round-robin, watchdog and reset sequences.
module tb_ll_req_arbiter;

  localparam int NR  = 4;
  localparam int DW  = 8;
  localparam int MN  = 8;
  localparam int AW  = 4;
  localparam int TO  = 4 * MN + 8;
  localparam int LAT = 2;

  typedef struct {
    int         req;
    logic [2:0] op;
    logic [7:0] data;
    logic [3:0] addr;
    logic       rej;
    logic       fault;
    logic [7:0] rdata;
    logic [3:0] rnext;
  } vec_t;

  typedef struct {
    logic [3:0] req_oh;
    logic       fault;
    logic [7:0] data;
    logic [3:0] nxt;
    int         lat;
  } exp_t;

  logic           clk;
  logic           rst;
  logic [NR-1:0]  req_valid;
  logic [NR-1:0]  req_ready;
  logic [NR*3-1:0]  req_op;
  logic [NR*DW-1:0] req_data;
  logic [NR*AW-1:0] req_addr;
  logic [NR-1:0]  rsp_valid;
  logic [DW-1:0]  rsp_data;
  logic [AW-1:0]  rsp_next_addr;
  logic           rsp_fault;
  logic           err_timeout;
  logic [2:0]     ll_op;
  logic           ll_op_start;
  logic [DW-1:0]  ll_data_in;
  logic [AW-1:0]  ll_addr_in;
  logic           ll_op_done;
  logic [DW-1:0]  ll_data_out;
  logic [AW-1:0]  ll_next_node_addr;
  logic           ll_fault;
  logic           ll_full;
  logic           ll_empty;

  int   total;
  int   bad;
  exp_t sb[$];
  vec_t vecs[13];
  logic hang;

  ll_req_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .MAX_NODE   (MN)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_op            (req_op),
    .req_data          (req_data),
    .req_addr          (req_addr),
    .rsp_valid         (rsp_valid),
    .rsp_data          (rsp_data),
    .rsp_next_addr     (rsp_next_addr),
    .rsp_fault         (rsp_fault),
    .err_timeout       (err_timeout),
    .ll_op             (ll_op),
    .ll_op_start       (ll_op_start),
    .ll_data_in        (ll_data_in),
    .ll_addr_in        (ll_addr_in),
    .ll_op_done        (ll_op_done),
    .ll_data_out       (ll_data_out),
    .ll_next_node_addr (ll_next_node_addr),
    .ll_fault          (ll_fault),
    .ll_full           (ll_full),
    .ll_empty          (ll_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- list model: slot i holds (data, addr given at insert)
  logic [7:0] mem [MN];
  logic [3:0] nad [MN];
  logic [3:0] mcnt;
  logic [3:0] m_lat;
  logic       m_seen;
  logic [3:0] fidx;

  always_comb begin
    fidx = 4'd8;
    for (int i = MN - 1; i >= 0; i--)
      if (4'(i) < mcnt && mem[i] == ll_data_in) fidx = 4'(i);
  end

  assign ll_full  = (mcnt == 4'd8);
  assign ll_empty = (mcnt == 4'd0);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcnt <= '0; m_lat <= '0; m_seen <= 1'b0; ll_op_done <= 1'b0;
      ll_data_out <= '0; ll_next_node_addr <= '0; ll_fault <= 1'b0;
    end else begin
      ll_op_done <= 1'b0;
      if (!ll_op_start) begin
        m_seen <= 1'b0;
        m_lat  <= '0;
      end else if (!m_seen && !hang) begin
        if (m_lat != 4'(LAT - 1)) begin
          m_lat <= m_lat + 4'd1;
        end else begin
          m_seen <= 1'b1; ll_op_done <= 1'b1; ll_fault <= 1'b0;
          ll_data_out <= 8'hEE; ll_next_node_addr <= 4'hE;
          case (ll_op[1:0])
            2'd0: if (ll_addr_in < mcnt) begin
                    ll_data_out <= mem[ll_addr_in[2:0]];
                    ll_next_node_addr <= nad[ll_addr_in[2:0]];
                  end else ll_fault <= 1'b1;
            2'd1: if (mcnt < 4'd8) begin
                    mem[mcnt[2:0]] <= ll_data_in;
                    nad[mcnt[2:0]] <= ll_addr_in;
                    mcnt <= mcnt + 4'd1;
                  end else ll_fault <= 1'b1;
            2'd2: if (fidx < 4'd8) begin
                    for (int j = 0; j < MN - 1; j++)
                      if (4'(j) >= fidx) begin mem[j] <= mem[j+1]; nad[j] <= nad[j+1]; end
                    mcnt <= mcnt - 4'd1;
                  end else ll_fault <= 1'b1;
            default: if (ll_addr_in < mcnt) begin
                    for (int j = 0; j < MN - 1; j++)
                      if (4'(j) >= ll_addr_in) begin mem[j] <= mem[j+1]; nad[j] <= nad[j+1]; end
                    mcnt <= mcnt - 4'd1;
                  end else ll_fault <= 1'b1;
          endcase
        end
      end
    end
  end

  // ---------------- checking helpers
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic set_slot(input int r, input logic [2:0] op, input logic [7:0] d, input logic [3:0] a);
    req_op   = (req_op   & ~(12'h007 << (3 * r))) | (12'(op) << (3 * r));
    req_data = (req_data & ~(32'h0000_00FF << (8 * r))) | (32'(d) << (8 * r));
    req_addr = (req_addr & ~(16'h000F << (4 * r))) | (16'(a) << (4 * r));
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      check("rsp_timeout", 32'(sb.size()), 0);
      sb.delete();
    end
  endtask

  task automatic run_one(input vec_t v);
    exp_t e;
    bit   got;
    e.req_oh = 4'b0001 << v.req;
    e.fault  = v.fault;
    e.data   = v.rdata;
    e.nxt    = v.rnext;
    e.lat    = v.rej ? 1 : (hang ? TO + 1 : LAT + 2);
    sb.push_back(e);
    @(posedge clk); #1;
    set_slot(v.req, v.op, v.data, v.addr);
    req_valid = e.req_oh;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if ((req_ready & e.req_oh) != 0) got = 1'b1;
    end
    if (!got) begin
      check("accept_timeout", 0, 1);
      req_valid = '0;
      sb.delete();
      return;
    end
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    check("ll_op_start_after_accept", 32'(ll_op_start), 32'(!v.rej));
    check("ll_captured", {ll_op, ll_data_in, ll_addr_in}, {v.op, v.data, v.addr});
    wait_drain(80);
  endtask

  // ---------------- monitor: one-hot, hold, latency and scoreboard pop
  int         mon_cyc;
  int         acc_cyc;
  logic       pstart;
  logic [14:0] phold;

  initial begin
    exp_t e;
    mon_cyc = 0; acc_cyc = 0; pstart = 1'b0; phold = '0;
    forever begin
      @(negedge clk);
      mon_cyc++;
      if (!rst) begin
        pstart = 1'b0;
      end else begin
        if (req_ready != 0) begin
          check("ready_onehot", 32'($onehot(req_ready)), 1);
          acc_cyc = mon_cyc;
        end
        if (pstart && ll_op_start)
          check("ll_inputs_held", {ll_op, ll_data_in, ll_addr_in}, phold);
        if (pstart && !ll_op_start)
          check("start_drops_in_resp", 32'(rsp_valid != 0), 1);
        if (!pstart && ll_op_start)
          check("start_one_after_accept", mon_cyc - acc_cyc, 1);
        if (rsp_valid != 0) begin
          if (sb.size() == 0) begin
            check("unexpected_rsp", 32'(rsp_valid), 0);
          end else begin
            e = sb.pop_front();
            check("rsp_valid_who", 32'(rsp_valid), 32'(e.req_oh));
            check("rsp_fault", 32'(rsp_fault), 32'(e.fault));
            check("rsp_data", 32'(rsp_data), 32'(e.data));
            check("rsp_next_addr", 32'(rsp_next_addr), 32'(e.nxt));
            check("rsp_latency", mon_cyc - acc_cyc, e.lat);
          end
        end
        pstart = ll_op_start;
        phold  = {ll_op, ll_data_in, ll_addr_in};
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got stuck want finish (bad=%0d)", bad);
    $fatal(1);
  end

  // ---------------- stimulus
  initial begin
    exp_t e;
    bit   got;
    total = 0; bad = 0; hang = 1'b0;
    rst = 1'b0; req_valid = '0; req_op = '0; req_data = '0; req_addr = '0;

    // req, op, data, addr, rej, fault, rdata, rnext (list holds 5 nodes on entry)
    vecs[0]  = '{2, 3'b001, 8'h5A, 4'd9, 1'b0, 1'b0, 8'h00, 4'd0};
    vecs[1]  = '{0, 3'b000, 8'h00, 4'd5, 1'b0, 1'b0, 8'h5A, 4'd9};
    vecs[2]  = '{1, 3'b000, 8'h00, 4'd7, 1'b0, 1'b1, 8'h00, 4'd0};
    vecs[3]  = '{3, 3'b010, 8'h77, 4'd0, 1'b0, 1'b1, 8'h00, 4'd0};
    vecs[4]  = '{1, 3'b001, 8'h66, 4'd6, 1'b0, 1'b0, 8'h00, 4'd0};
    vecs[5]  = '{0, 3'b101, 8'h11, 4'd3, 1'b0, 1'b0, 8'h00, 4'd0};
    vecs[6]  = '{3, 3'b001, 8'h44, 4'd2, 1'b1, 1'b1, 8'h00, 4'd0};
    vecs[7]  = '{3, 3'b010, 8'h5A, 4'd0, 1'b0, 1'b0, 8'h00, 4'd0};
    vecs[8]  = '{2, 3'b000, 8'h00, 4'd5, 1'b0, 1'b0, 8'h66, 4'd6};
    vecs[9]  = '{1, 3'b011, 8'h00, 4'd0, 1'b0, 1'b0, 8'h00, 4'd0};
    vecs[10] = '{0, 3'b000, 8'h00, 4'd0, 1'b0, 1'b0, 8'h21, 4'd1};
    vecs[11] = '{2, 3'b110, 8'h11, 4'd0, 1'b0, 1'b0, 8'h00, 4'd0};
    vecs[12] = '{3, 3'b000, 8'h00, 4'd4, 1'b0, 1'b0, 8'h66, 4'd6};

    #12;
    check("reset_rsp_outputs", {req_ready, rsp_valid, rsp_data, rsp_next_addr, rsp_fault, err_timeout},
          32'h0);
    check("reset_ll_outputs", {ll_op, ll_op_start, ll_data_in, ll_addr_in}, 32'h0);
    @(posedge clk); #1;

    // Round robin from reset: all four request inserts continuously.
    for (int r = 0; r < NR; r++) set_slot(r, 3'b001, 8'(8'h20 + r), 4'(r));
    for (int k = 0; k < 5; k++) begin
      e.req_oh = 4'b0001 << (k % NR); e.fault = 1'b0; e.data = '0; e.nxt = '0; e.lat = LAT + 2;
      sb.push_back(e);
    end
    rst = 1'b1;
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        if (req_ready != 0) got = 1'b1;
      end
      check("rr_grant_order", 32'(req_ready), 32'(4'b0001 << (k % NR)));
    end
    @(posedge clk); #1;
    req_valid = '0;
    wait_drain(40);

    for (int i = 0; i < 13; i++) run_one(vecs[i]);
    check("no_timeout_yet", 32'(err_timeout), 0);

    // Hung list: watchdog fails the op, later requests still proceed.
    hang = 1'b1;
    run_one('{0, 3'b001, 8'h99, 4'd1, 1'b0, 1'b1, 8'h00, 4'd0});
    check("err_timeout_set", 32'(err_timeout), 1);
    hang = 1'b0;
    run_one('{1, 3'b000, 8'h00, 4'd0, 1'b0, 1'b0, 8'h21, 4'd1});
    check("err_timeout_sticky", 32'(err_timeout), 1);

    // Reset in the middle of ISSUE.
    hang = 1'b1;
    @(posedge clk); #1;
    set_slot(2, 3'b001, 8'h33, 4'd3);
    req_valid = 4'b0100;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (req_ready[2]) got = 1'b1;
    end
    check("mid_reset_accept", 32'(got), 1);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (4) @(negedge clk);
    check("mid_reset_in_issue", 32'(ll_op_start), 1);
    #2 rst = 1'b0;
    #1;
    check("mid_reset_rsp_outputs", {req_ready, rsp_valid, rsp_data, rsp_next_addr, rsp_fault, err_timeout},
          32'h0);
    check("mid_reset_ll_outputs", {ll_op, ll_op_start, ll_data_in, ll_addr_in}, 32'h0);
    @(negedge clk);
    @(posedge clk); #1;
    hang = 1'b0;
    for (int r = 0; r < NR; r++) set_slot(r, 3'b000, 8'h00, 4'd0);
    e.req_oh = 4'b0001; e.fault = 1'b1; e.data = '0; e.nxt = '0; e.lat = 1;
    sb.push_back(e);
    rst = 1'b1;
    req_valid = 4'b1111;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (req_ready != 0) got = 1'b1;
    end
    check("post_reset_grant", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    req_valid = '0;
    wait_drain(20);
    check("err_timeout_cleared", 32'(err_timeout), 0);

    // Empty-list rejections, then an insert still goes to the list.
    run_one('{1, 3'b000, 8'h00, 4'd0, 1'b1, 1'b1, 8'h00, 4'd0});
    run_one('{2, 3'b010, 8'h5A, 4'd0, 1'b1, 1'b1, 8'h00, 4'd0});
    run_one('{0, 3'b011, 8'h00, 4'd0, 1'b1, 1'b1, 8'h00, 4'd0});
    run_one('{3, 3'b001, 8'h42, 4'd2, 1'b0, 1'b0, 8'h00, 4'd0});

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
